// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master, MSB first, one full-duplex word per transaction.
// Define SPI_CTRL_LOOPBACK_EN to add a loopback input that samples mosi instead of miso.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int SS_SETUP   = 4,
  parameter int SS_HOLD    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  ss_n,
  output logic                  mosi,
  input  logic                  miso
`ifdef SPI_CTRL_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_master_ctrl: CLK_DIV must be >= 4");
  end
  if (SS_SETUP < 1 || SS_HOLD < 1) begin : g_bad_ss
    $error("spi_master_ctrl: SS_SETUP and SS_HOLD must be >= 1");
  end
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("spi_master_ctrl: DATA_WIDTH must be >= 2");
  end

  localparam int CNT_MAX_A = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int CNT_MAX   = (CNT_MAX_A > SS_HOLD) ? CNT_MAX_A : SS_HOLD;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam int BIT_W     = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_DONE, S_GAP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_sr;
  logic [DATA_WIDTH-1:0] r_rx_sr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sclk;
  logic                  r_ss_n;
  logic                  r_mosi;
  logic                  r_miso_s1;
  logic                  r_miso_s2;
  logic                  w_sample;

`ifdef SPI_CTRL_LOOPBACK_EN
  assign w_sample = loopback ? r_mosi : r_miso_s2;
`else
  assign w_sample = r_miso_s2;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tx_sr   <= tx_data;
            r_rx_sr   <= '0;
            r_bit_cnt <= BIT_LAST;
            r_cnt     <= SETUP_LAST;
            r_mosi    <= tx_data[DATA_WIDTH-1];
            r_ss_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_cnt   <= DIV_LAST;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == '0) begin
            r_cnt   <= DIV_LAST;
            r_sclk  <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HIGH: begin
          // Sampling late in HIGH leaves room for the peripheral's synchroniser latency.
          if (r_cnt == '0) begin
            r_sclk  <= 1'b0;
            r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], w_sample};
            if (r_bit_cnt != '0) begin
              r_tx_sr   <= r_tx_sr << 1;
              r_mosi    <= r_tx_sr[DATA_WIDTH-2];
              r_bit_cnt <= r_bit_cnt - 1'b1;
              r_cnt     <= DIV_LAST;
              r_state   <= S_LOW;
            end else begin
              r_mosi  <= 1'b0;
              r_cnt   <= HOLD_LAST;
              r_state <= S_HOLD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_ss_n    <= 1'b1;
            r_rx_data <= r_rx_sr;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_cnt   <= DIV_LAST;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign ss_n    = r_ss_n;
  assign mosi    = r_mosi;

endmodule
